// File: rtl/t05_sram_arbiter_if.sv
// rtl/t05_sram_arbiter_if.sv - requester/SRAM bundle for t05_sram_arbiter
// Purpose: carries the per-requester request/response handshake and the
//   single wishbone SRAM master port shared by the requesters.
// Ports: per-requester fields are packed, slice i belongs to requester i.
//   master modport = arbiter view, slave modport = requesters + SRAM view.
interface t05_sram_arbiter_if #(
  parameter int NREQ = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ*4-1:0]  req_sel;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_err;
  logic [31:0]        rsp_rdata;
  logic               mem_wr_en;
  logic               mem_r_en;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_sel;
  logic               mem_busy;
  logic [31:0]        mem_rdata;
  logic [2:0]         grant_id;

  modport master (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, req_sel,
    input  mem_busy, mem_rdata,
    output req_ack, req_err, rsp_rdata,
    output mem_wr_en, mem_r_en, mem_addr, mem_wdata, mem_sel, grant_id
  );

  modport slave (
    output req_valid, req_we, req_lock, req_addr, req_wdata, req_sel,
    output mem_busy, mem_rdata,
    input  req_ack, req_err, rsp_rdata,
    input  mem_wr_en, mem_r_en, mem_addr, mem_wdata, mem_sel, grant_id
  );
endinterface

// File: rtl/t05_sram_arbiter.sv
// rtl/t05_sram_arbiter.sv - round-robin SRAM arbiter and transaction sequencer
// Purpose: grants one of NREQ requesters, issues a single-cycle read/write
//   strobe on the shared SRAM port, tracks the busy handshake with a timeout,
//   and returns read data with a one-cycle ack (err-qualified) to the grantee.
// Ports: clk, rst (async, active-high); bus (master modport) carries the
//   requester handshake, the SRAM master port and grant_id.
module t05_sram_arbiter #(
  parameter int          NREQ      = 5,
  parameter logic [31:0] ADDR_LO   = 32'h3300_0000,
  parameter logic [31:0] ADDR_HI   = 32'h3300_3FFC,
  parameter int          TIMEOUT   = 255,
  parameter int          MAX_BURST = 8
) (
  input logic                clk,
  input logic                rst,
  t05_sram_arbiter_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    RESP       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    sel_q, sel_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    rr_q, rr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] timer_q, timer_d;

  // Winner search: first pending requester at or above rr_q, wrapping.
  logic        win_found;
  logic [2:0]  win_idx;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_sel;
  int          cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && bus.req_valid[3'(cand)]) begin
        win_found = 1'b1;
        win_idx   = 3'(cand);
      end
    end
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == 3'(k)) begin
        win_we    = bus.req_we[k];
        win_addr  = bus.req_addr[32*k +: 32];
        win_wdata = bus.req_wdata[32*k +: 32];
        win_sel   = bus.req_sel[4*k +: 4];
      end
    end
  end

  logic addr_bad;
  assign addr_bad = (win_addr < ADDR_LO) || (win_addr > ADDR_HI) ||
                    (win_addr[1:0] != 2'b00);

  // The count after this cycle; >= so that a busy rising exactly at the
  // limit cannot step past the compare and hang in WAIT_DONE.
  logic [TW-1:0] timer_inc;
  logic          timed_out;
  assign timer_inc = timer_q + TW'(1);
  assign timed_out = (timer_inc >= TW'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (win_found && !bus.mem_busy) begin
          gnt_d   = win_idx;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          sel_d   = win_sel;
          err_d   = addr_bad;
          state_d = addr_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        timer_d = timer_inc;
        if (bus.mem_busy) begin
          state_d = WAIT_DONE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_inc;
        if (!bus.mem_busy) begin
          if (!we_q) rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        // A locked grantee keeps the pointer for up to MAX_BURST grants;
        // any error response releases it.
        if (!err_q && bus.req_lock[gnt_q] && (int'(burst_q) < MAX_BURST - 1)) begin
          rr_d    = gnt_q;
          burst_d = burst_q + BW'(1);
        end else begin
          rr_d    = (int'(gnt_q) == NREQ - 1) ? 3'd0 : gnt_q + 3'd1;
          burst_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      timer_q <= timer_d;
    end
  end

  // Outputs decode from registered state so reset clears them at once.
  logic [NREQ-1:0] ack_vec;
  always_comb begin
    ack_vec = '0;
    if (state_q == RESP) ack_vec[gnt_q] = 1'b1;
  end

  assign bus.req_ack   = ack_vec;
  assign bus.req_err   = ack_vec & {NREQ{err_q}};
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_wr_en = (state_q == ISSUE) && we_q;
  assign bus.mem_r_en  = (state_q == ISSUE) && !we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_sel   = sel_q;
  assign bus.grant_id  = gnt_q;

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// tb/tb_t05_sram_arbiter.sv - self-checking bench for t05_sram_arbiter
module tb_t05_sram_arbiter;
  localparam int          NREQ    = 5;
  localparam logic [31:0] ADDR_LO = 32'h3300_0000;
  localparam logic [31:0] ADDR_HI = 32'h3300_3FFC;
  localparam int          TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t05_sram_arbiter_if #(.NREQ(NREQ)) arb ();

  t05_sram_arbiter #(
    .NREQ(NREQ), .ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI),
    .TIMEOUT(TIMEOUT), .MAX_BURST(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(arb)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle index: cycle k is the interval after rising edge k.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // SRAM bus model: reacts to a strobe, holds busy for busy_len cycles.
  logic [31:0] bus_mem [4096];
  logic [31:0] ref_mem [4096];
  logic [31:0] rd_q = '0;
  int          busy_left = 0;
  int          busy_len  = 1;
  bit          hang      = 1'b0;
  int          strobe_cnt = 0;
  int          strobe_cyc = 0;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;

  assign arb.mem_rdata = rd_q;
  assign arb.mem_busy  = (busy_left > 0);

  always @(negedge clk) begin
    if (arb.mem_r_en || arb.mem_wr_en) begin
      strobe_cnt++;
      strobe_cyc = cyc;
      s_we    = arb.mem_wr_en;
      s_addr  = arb.mem_addr;
      s_wdata = arb.mem_wdata;
      s_sel   = arb.mem_sel;
      if (!hang) begin
        if (arb.mem_wr_en) begin
          for (int b = 0; b < 4; b++)
            if (arb.mem_sel[b]) bus_mem[arb.mem_addr[13:2]][8*b +: 8] = arb.mem_wdata[8*b +: 8];
        end else begin
          rd_q = bus_mem[arb.mem_addr[13:2]];
        end
        busy_left = busy_len + 1;
      end
    end else if (busy_left > 0) begin
      busy_left--;
    end
  end

  // Per-requester request queues and reference arbitration state.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } rq_t;

  rq_t         rq [NREQ][16];
  int          hd [NREQ];
  int          tl [NREQ];
  bit          lk [NREQ];
  int          m_rr = 0;
  int          m_burst = 0;
  logic [31:0] exp_rdata = '0;

  task automatic push(input int i, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    rq[i][tl[i]] = '{we: we, addr: a, wdata: d, sel: s};
    tl[i]++;
  endtask

  task automatic present(input int i);
    if (hd[i] < tl[i]) begin
      arb.req_valid[i]          = 1'b1;
      arb.req_we[i]             = rq[i][hd[i]].we;
      arb.req_addr[32*i +: 32]  = rq[i][hd[i]].addr;
      arb.req_wdata[32*i +: 32] = rq[i][hd[i]].wdata;
      arb.req_sel[4*i +: 4]     = rq[i][hd[i]].sel;
    end else begin
      arb.req_valid[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] ok_addr();
    return ADDR_LO + 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic push_rand(input int i, input bit allow_fault);
    logic [31:0] a;
    a = ok_addr();
    if (allow_fault && $urandom_range(0, 5) == 0)
      a = ($urandom_range(0, 1) == 0) ? ADDR_HI + 32'd4 : a + 32'd1;
    push(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(1, 15)));
  endtask

  // Serve every queued request, predicting each grant from the rules.
  task automatic run_all();
    int t0, w, c, lat, sc0, n;
    bit flt, err, pending;
    rq_t r;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      present(i);
      arb.req_lock[i] = lk[i];
    end
    t0 = cyc;
    pending = 1'b1;
    while (pending) begin
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_rr + k) % NREQ;
        if (w < 0 && hd[c] < tl[c]) w = c;
      end
      r   = rq[w][hd[w]];
      flt = (r.addr < ADDR_LO) || (r.addr > ADDR_HI) || (r.addr[1:0] != 2'b00);
      err = flt || hang;
      lat = flt ? 1 : (hang ? TIMEOUT + 2 : 3 + busy_len);
      sc0 = strobe_cnt;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (arb.req_ack == '0 && n < 400);
      chk("ack_seen", 64'(arb.req_ack != '0), 64'd1);
      chk("ack_cycle", 64'(cyc), 64'(t0 + lat));
      chk("ack_vec", 64'(arb.req_ack), 64'(5'b00001 << w));
      chk("err_vec", 64'(arb.req_err), err ? 64'(5'b00001 << w) : 64'd0);
      chk("grant_id", 64'(arb.grant_id), 64'(w));
      chk("strobes", 64'(strobe_cnt), 64'(sc0 + (flt ? 0 : 1)));
      if (!flt) begin
        chk("strobe_cyc", 64'(strobe_cyc), 64'(t0 + 1));
        chk("strobe_req", {s_we, s_addr, s_sel}, {r.we, r.addr, r.sel});
        if (r.we) chk("strobe_wdata", 64'(s_wdata), 64'(r.wdata));
      end
      if (!err && r.we) begin
        for (int b = 0; b < 4; b++)
          if (r.sel[b]) ref_mem[r.addr[13:2]][8*b +: 8] = r.wdata[8*b +: 8];
      end
      if (!err && !r.we) exp_rdata = ref_mem[r.addr[13:2]];
      chk("rsp_rdata", 64'(arb.rsp_rdata), 64'(exp_rdata));
      if (!err && lk[w] && m_burst < 7) begin
        m_rr = w;
        m_burst++;
      end else begin
        m_rr = (w + 1) % NREQ;
        m_burst = 0;
      end
      hd[w]++;
      present(w);
      t0 = cyc + 1;
      pending = 1'b0;
      for (int i = 0; i < NREQ; i++) if (hd[i] < tl[i]) pending = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus"}, {arb.mem_wr_en, arb.mem_r_en, arb.mem_sel, arb.mem_addr}, 64'd0);
    chk({tag, "_wdata"}, 64'(arb.mem_wdata), 64'd0);
    chk({tag, "_rsp"}, {arb.req_ack, arb.req_err, arb.grant_id, arb.rsp_rdata}, 64'd0);
  endtask

  initial begin
    int n, sc0, seen;
    for (int i = 0; i < 4096; i++) begin
      bus_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_A5A5;
      ref_mem[i] = bus_mem[i];
    end
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      lk[i] = 1'b0;
    end
    arb.req_valid = '0;
    arb.req_we    = '0;
    arb.req_lock  = '0;
    arb.req_addr  = '0;
    arb.req_wdata = '0;
    arb.req_sel   = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Contention among 0, 1 and 4 from rr_ptr=0: expect 0,1,4,0,1,4.
    busy_len = 1;
    for (int j = 0; j < 2; j++) begin
      push_rand(0, 1'b0);
      push_rand(1, 1'b0);
      push_rand(4, 1'b0);
    end
    run_all();

    // Single read of a known word.
    bus_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    push(2, 1'b0, 32'h3300_0010, 32'h0, 4'hF);
    run_all();

    // Burst lock on requester 3 with 0 competing.
    lk[3] = 1'b1;
    for (int j = 0; j < 10; j++) push_rand(3, 1'b0);
    push_rand(0, 1'b0);
    push_rand(0, 1'b0);
    run_all();
    lk[3] = 1'b0;

    // Bus hang on a write, then a normal read by another requester.
    hang = 1'b1;
    push(1, 1'b1, ADDR_LO + 32'h40, 32'h1234_5678, 4'hF);
    run_all();
    hang = 1'b0;
    push(2, 1'b0, ADDR_LO + 32'h40, 32'h0, 4'hF);
    run_all();

    // Address window and alignment boundaries.
    push(0, 1'b0, 32'h3300_4000, 32'h0, 4'hF);
    push(1, 1'b1, 32'h3300_0002, 32'hCAFE_F00D, 4'hF);
    push(2, 1'b1, ADDR_HI, 32'hA5A5_0001, 4'hF);
    push(3, 1'b0, ADDR_LO - 32'd4, 32'h0, 4'hF);
    push(4, 1'b0, ADDR_HI, 32'h0, 4'hF);
    push(0, 1'b0, ADDR_LO, 32'h0, 4'hF);
    run_all();

    // Randomized mixes with random locks and bus latencies.
    for (int rnd = 0; rnd < 3; rnd++) begin
      busy_len = $urandom_range(1, 3);
      for (int i = 0; i < NREQ; i++) lk[i] = 1'($urandom_range(0, 1));
      for (int j = 0; j < 14; j++) push_rand($urandom_range(0, NREQ - 1), 1'b1);
      run_all();
    end
    for (int i = 0; i < NREQ; i++) lk[i] = 1'b0;

    // Reset while waiting for the bus to finish.
    busy_len = 8;
    @(negedge clk);
    push(2, 1'b0, ADDR_LO + 32'h8, 32'h0, 4'hF);
    present(2);
    sc0 = strobe_cnt;
    n = 0;
    while (strobe_cnt == sc0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midop_strobe", 64'(strobe_cnt), 64'(sc0 + 1));
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("midop_rst");
    arb.req_valid = '0;
    hd[2] = tl[2];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (arb.req_ack != '0) seen++;
    end
    chk("no_ack_after_rst", 64'(seen), 64'd0);
    m_rr = 0;
    m_burst = 0;
    exp_rdata = '0;
    busy_len = 1;
    push(2, 1'b0, ADDR_LO + 32'h8, 32'h0, 4'hF);
    push(3, 1'b1, ADDR_LO + 32'hC, 32'h0BAD_F00D, 4'h5);
    run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/t05_sram_arbiter.md
Name: t05_sram_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares the single wishbone SRAM master port among NREQ pipeline requesters: histogram, FLV, htree, codebook and translation. Each requester issues single-word read or write requests. The arbiter grants one requester, drives a one-cycle strobe to the bus, tracks the busy handshake, and returns read data with a done pulse. Out-of-window addresses and bus hangs are reported as errors rather than stalling the pipeline.

Parameters:
NREQ, 5, number of requesters (index 0..NREQ-1)
ADDR_LO, 32'h3300_0000, lowest legal byte address (inclusive)
ADDR_HI, 32'h3300_3FFC, highest legal byte address (inclusive)
TIMEOUT, 255, max cycles from strobe to busy falling before error
MAX_BURST, 8, max consecutive grants to one locked requester

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  request pending, held until req_ack
req_we  in  NREQ  1=write, 0=read
req_lock  in  NREQ  keep priority for the next request (burst)
req_addr  in  NREQ*32  byte address, slice i = [32*i+31:32*i]
req_wdata  in  NREQ*32  write data per requester
req_sel  in  NREQ*4  byte select per requester
req_ack  out  NREQ  one-cycle done pulse to the granted requester
req_err  out  NREQ  qualifies req_ack: 1=address fault or timeout
rsp_rdata  out  32  read data, valid in the req_ack cycle
mem_wr_en  out  1  write strobe
mem_r_en  out  1  read strobe
mem_addr  out  32  bus address
mem_wdata  out  32  bus write data
mem_sel  out  4  bus byte select
mem_busy  in  1  bus busy (busy_o)
mem_rdata  in  32  bus read data (data_o)
grant_id  out  3  index of current/last grantee, for debug

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0; burst_cnt=0; timer=0. Reset is asynchronous and may occur in any state. Strobes and ack drop immediately, and no partial ack is produced afterwards.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE:
  - When any req_valid and !mem_busy, select the winner g: the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch g, we, addr, wdata and sel; set grant_id=g.
  - If the latched addr is outside [ADDR_LO, ADDR_HI] or addr[1:0]!=0, go to RESP with the error flag set and issue no strobe. Otherwise go to ISSUE.
  - If mem_busy=1, wait in IDLE.
- ISSUE:
  - Drive mem_addr, mem_wdata and mem_sel from the latch.
  - Assert mem_wr_en (we=1) or mem_r_en (we=0) for exactly this one cycle.
  - Clear timer; go to WAIT_START.
- WAIT_START: wait for mem_busy=1, then go to WAIT_DONE. Hold mem_addr, mem_wdata and mem_sel stable; strobes are 0.
- WAIT_DONE: on the first cycle with mem_busy=0, register mem_rdata into rsp_rdata (reads only; writes leave rsp_rdata unchanged). Go to RESP.
- Timeout: timer increments each cycle in WAIT_START and WAIT_DONE. On timer==TIMEOUT, go to RESP with the error flag set; rsp_rdata is unchanged.
- RESP:
  - Pulse req_ack[g]=1 and req_err[g]=flag for one cycle, then return to IDLE.
  - The winner is re-arbitrated from IDLE on the next cycle, so a requester deasserting req_valid after sampling ack is never double-served.
- Minimum latency, with a 1-cycle busy pulse: req seen at cycle 0 → strobe at 1 → busy at 2 → busy low at 3 → ack at 4. Address fault: ack+err at cycle 1.
- Round-robin update, applied in RESP:
  - If req_lock[g]=1 and burst_cnt<MAX_BURST-1: rr_ptr=g and burst_cnt++.
  - Else: rr_ptr=(g+1) mod NREQ and burst_cnt=0.
  - Error responses always release: the else branch applies.
- Only one transaction is outstanding at a time. Requests from non-granted requesters are ignored until IDLE; they hold req_valid.
- Simultaneous requests are resolved purely by rr_ptr order, with no fixed priority. A requester whose req_valid drops before grant is simply not selected.

Test Plan:
- Single read: req_valid[2]=1, addr 32'h3300_0010; bus busy 1 cycle, rdata 32'hDEAD_BEEF → mem_r_en pulse at cycle 1, req_ack[2] at cycle 4, rsp_rdata=32'hDEAD_BEEF, req_err=0.
- Contention: requesters 0, 1 and 4 assert together and re-request after each ack → grant order 0,1,4,0,1,4; rr_ptr advances correctly past the wrap.
- Burst lock: req_lock[3]=1 with continuous requests from 3 and 0 → exactly 8 consecutive grants to 3, then 0, then 3 again.
- Timeout: mem_busy never rises after a write strobe → req_ack[1]=1 with req_err[1]=1 at 1+TIMEOUT+1 cycles; the arbiter then serves the next request normally.
- Address fault: addr 32'h3300_4000, and separately 32'h3300_0002 → ack+err the cycle after latch, with no mem_wr_en/mem_r_en ever asserted.
- Reset mid-op: assert rst during WAIT_DONE → all outputs 0 immediately, no ack on release; a fresh request completes normally.
